// File: rtl/step_tracker.sv
`default_nettype none
// ============================================================================
// Module   : step_tracker
// Purpose  : Step/push counter with bounded undo history for a box-pushing game.
// Revision : 1.0
// ============================================================================
module step_tracker #(
    parameter int UNDO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level_load_i,
    input  logic [7:0] level_exp_i,
    input  logic       move_ok_i,
    input  logic       move_push_i,
    input  logic       undo_req_i,
    output logic [7:0] step_o,
    output logic [7:0] step_exp_o,
    output logic [7:0] push_cnt_o,
    output logic       undo_ok_o,
    output logic       undo_push_o,
    output logic       undo_nack_o,
    output logic       hist_empty_o,
    output logic       over_par_o,
    output logic       step_sat_o
);

    localparam int              c_PTR_W   = $clog2(UNDO_DEPTH);
    localparam int              c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(UNDO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [7:0]         c_MAX8    = 8'hFF;

    logic [7:0]         step_q,     step_d;
    logic [7:0]         exp_q,      exp_d;
    logic [7:0]         push_q,     push_d;
    logic [c_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_CNT_W-1:0] count_q,    count_d;
    logic               undo_ok_q,  undo_ok_d;
    logic               undo_push_q, undo_push_d;
    logic               undo_nack_q, undo_nack_d;
    logic               empty_q,    empty_d;
    logic               over_q,     over_d;
    logic               sat_q,      sat_d;

    // One bit per remembered move: did it push a box.
    logic [UNDO_DEPTH-1:0] hist_q;

    logic [c_PTR_W-1:0] w_rd_idx;
    logic               w_rd_bit;
    logic               w_hist_we;

    assign w_rd_idx = wr_ptr_q - c_PTR_ONE;
    assign w_rd_bit = hist_q[w_rd_idx];

    always_comb begin
        step_d      = step_q;
        exp_d       = exp_q;
        push_d      = push_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        undo_ok_d   = 1'b0;
        undo_push_d = 1'b0;
        undo_nack_d = 1'b0;
        w_hist_we   = 1'b0;

        if (level_load_i) begin
            step_d  = 8'd0;
            push_d  = 8'd0;
            count_d = '0;
            exp_d   = level_exp_i;
        end else if (undo_req_i) begin
            if (count_q != '0) begin
                wr_ptr_d    = w_rd_idx;
                count_d     = count_q - c_CNT_ONE;
                step_d      = (step_q != 8'd0) ? step_q - 8'd1 : 8'd0;
                push_d      = (w_rd_bit && push_q != 8'd0) ? push_q - 8'd1 : push_q;
                undo_ok_d   = 1'b1;
                undo_push_d = w_rd_bit;
            end else begin
                undo_nack_d = 1'b1;
            end
        end else if (move_ok_i) begin
            // History is written even once step has saturated, so undo stays consistent.
            w_hist_we = 1'b1;
            wr_ptr_d  = wr_ptr_q + c_PTR_ONE;
            if (count_q != c_DEPTH) begin
                count_d = count_q + c_CNT_ONE;
            end
            step_d = (step_q != c_MAX8) ? step_q + 8'd1 : step_q;
            push_d = (move_push_i && push_q != c_MAX8) ? push_q + 8'd1 : push_q;
        end

        empty_d = (count_d == '0);
        over_d  = (step_d > exp_d);
        sat_d   = (step_d == c_MAX8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q      <= 8'd0;
            exp_q       <= 8'd0;
            push_q      <= 8'd0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            undo_ok_q   <= 1'b0;
            undo_push_q <= 1'b0;
            undo_nack_q <= 1'b0;
            empty_q     <= 1'b1;
            over_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            step_q      <= step_d;
            exp_q       <= exp_d;
            push_q      <= push_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            undo_ok_q   <= undo_ok_d;
            undo_push_q <= undo_push_d;
            undo_nack_q <= undo_nack_d;
            empty_q     <= empty_d;
            over_q      <= over_d;
            sat_q       <= sat_d;
        end
    end

    // Entries beyond count are never read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_hist_we) begin
            hist_q[wr_ptr_q] <= move_push_i;
        end
    end

    assign step_o       = step_q;
    assign step_exp_o   = exp_q;
    assign push_cnt_o   = push_q;
    assign undo_ok_o    = undo_ok_q;
    assign undo_push_o  = undo_push_q;
    assign undo_nack_o  = undo_nack_q;
    assign hist_empty_o = empty_q;
    assign over_par_o   = over_q;
    assign step_sat_o   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_step_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_tracker
// Purpose  : Directed scoreboard bench for step_tracker against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_step_tracker;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       level_load, move_ok, move_push, undo_req;
    logic [7:0] level_exp;
    logic [7:0] step, step_exp, push_cnt;
    logic       undo_ok, undo_push, undo_nack, hist_empty, over_par, step_sat;

    always #5 clk = ~clk;

    step_tracker #(.UNDO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .level_load_i(level_load),
        .level_exp_i (level_exp),
        .move_ok_i   (move_ok),
        .move_push_i (move_push),
        .undo_req_i  (undo_req),
        .step_o      (step),
        .step_exp_o  (step_exp),
        .push_cnt_o  (push_cnt),
        .undo_ok_o   (undo_ok),
        .undo_push_o (undo_push),
        .undo_nack_o (undo_nack),
        .hist_empty_o(hist_empty),
        .over_par_o  (over_par),
        .step_sat_o  (step_sat)
    );

    typedef struct packed {
        logic [7:0] step;
        logic [7:0] exp;
        logic [7:0] push;
        logic       ok;
        logic       upush;
        logic       nack;
        logic       empty;
        logic       over;
        logic       sat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: history kept as a queue of push bits, newest at the back.
    int   m_step = 0, m_exp = 0, m_push = 0;
    bit   m_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cycle(input bit rs, input bit ld, input logic [7:0] le,
                         input bit un, input bit mv, input bit mp);
        exp_t e;
        exp_t got;
        bit   b;
        rst_n = rs; level_load = ld; level_exp = le;
        undo_req = un; move_ok = mv; move_push = mp;
        e = '0;
        if (!rs) begin
            m_step = 0; m_exp = 0; m_push = 0; m_hist.delete();
        end else if (ld) begin
            m_step = 0; m_push = 0; m_exp = le; m_hist.delete();
        end else if (un) begin
            if (m_hist.size() > 0) begin
                b = m_hist.pop_back();
                if (m_step > 0) m_step--;
                if (b && m_push > 0) m_push--;
                e.ok = 1'b1; e.upush = b;
            end else begin
                e.nack = 1'b1;
            end
        end else if (mv) begin
            m_hist.push_back(mp);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            if (m_step < 255) m_step++;
            if (mp && m_push < 255) m_push++;
        end
        e.step  = 8'(m_step);
        e.exp   = 8'(m_exp);
        e.push  = 8'(m_push);
        e.empty = (m_hist.size() == 0);
        e.over  = (m_step > m_exp);
        e.sat   = (m_step == 255);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = '{step, step_exp, push_cnt, undo_ok, undo_push, undo_nack,
                hist_empty, over_par, step_sat};
        e = sb_q.pop_front();
        check("scoreboard", 32'(got), 32'(e));
    endtask

    task automatic mv1(input bit p);  cycle(1, 0, 8'd0, 0, 1, p); endtask
    task automatic undo1();           cycle(1, 0, 8'd0, 1, 0, 0); endtask
    task automatic load(input logic [7:0] le); cycle(1, 1, le, 0, 0, 0); endtask

    initial begin
        rst_n = 1'b0; level_load = 0; level_exp = 0; move_ok = 0; move_push = 0; undo_req = 0;

        // Reset, with pulses asserted to show they are overridden.
        cycle(0, 0, 8'd0, 0, 0, 0);
        cycle(0, 1, 8'd9, 1, 1, 1);
        check("reset_empty", 32'(hist_empty), 32'd1);
        check("reset_step", 32'(step), 32'd0);

        // Three moves, push on the second.
        load(8'd20);
        mv1(0); mv1(1); mv1(0);
        check("seq_step", 32'(step), 32'd3);
        check("seq_push", 32'(push_cnt), 32'd1);
        check("seq_exp", 32'(step_exp), 32'd20);
        check("seq_over", 32'(over_par), 32'd0);
        check("seq_empty", 32'(hist_empty), 32'd0);

        // Undo all three then one refused.
        undo1(); check("u1_push", 32'(undo_push), 32'd0);
        undo1(); check("u2_push", 32'(undo_push), 32'd1);
        undo1(); check("u3_push", 32'(undo_push), 32'd0);
        undo1(); check("u4_nack", 32'(undo_nack), 32'd1);
        check("u4_pushbit", 32'(undo_push), 32'd0);
        check("undo_step", 32'(step), 32'd0);
        check("undo_pcnt", 32'(push_cnt), 32'd0);
        check("undo_empty", 32'(hist_empty), 32'd1);

        // Depth bound: 20 moves, 17 undos.
        load(8'd100);
        for (int i = 0; i < 20; i++) mv1(0);
        for (int i = 0; i < 16; i++) begin
            undo1();
            check("deep_ok", 32'(undo_ok), 32'd1);
        end
        undo1();
        check("deep_nack", 32'(undo_nack), 32'd1);
        check("deep_step", 32'(step), 32'd4);

        // Wrapped history with mixed push pattern.
        load(8'd50);
        for (int i = 0; i < 21; i++) mv1(((i * 7) % 3) == 0);
        for (int i = 0; i < 17; i++) undo1();

        // Over-par and saturation.
        load(8'd5);
        for (int i = 0; i < 5; i++) mv1(0);
        check("par_before", 32'(over_par), 32'd0);
        mv1(1);
        check("par_after", 32'(over_par), 32'd1);
        for (int i = 0; i < 252; i++) mv1(i[0]);
        check("sat_step", 32'(step), 32'd255);
        check("sat_flag", 32'(step_sat), 32'd1);
        undo1();
        check("sat_undo", 32'(step), 32'd254);
        check("sat_clear", 32'(step_sat), 32'd0);

        // Priority: load beats undo and move; undo beats move.
        cycle(1, 1, 8'd30, 1, 1, 1);
        check("pri_load_step", 32'(step), 32'd0);
        check("pri_load_ok", 32'({undo_ok, undo_nack}), 32'd0);
        mv1(1);
        cycle(1, 0, 8'd0, 1, 1, 0);
        check("pri_undo_ok", 32'(undo_ok), 32'd1);
        check("pri_undo_step", 32'(step), 32'd0);
        cycle(1, 0, 8'd0, 0, 0, 0);
        check("idle_ok", 32'(undo_ok), 32'd0);

        // Mid-sequence reset.
        for (int i = 0; i < 7; i++) mv1(1);
        check("pre_rst_step", 32'(step), 32'd7);
        cycle(0, 0, 8'd0, 0, 1, 1);
        check("rst_step", 32'(step), 32'd0);
        check("rst_exp", 32'(step_exp), 32'd0);
        undo1();
        check("rst_nack", 32'(undo_nack), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
